bcd_seq_conv: RTL and testbench



---
 rtl/bcd_pkg.sv | 27 ++
 rtl/bcd_digit_adj.sv | 16 +
 rtl/bcd_seq_conv.sv | 123 ++++++++++++
 tb/tb_bcd_seq_conv.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and elaboration helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    localparam int unsigned BCD_DIGIT_W = 4;

    function automatic int unsigned clog2(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    // Digits needed to show 2^bin_w - 1 without overflow.
    function automatic int unsigned min_digits(input int unsigned bin_w);
        longint unsigned maxv;
        int unsigned     d;
        maxv = (64'd1 << bin_w) - 64'd1;
        d    = 1;
        for (int i = 0; i < 20; i++) begin
            if (maxv >= 64'd10) begin
                maxv = maxv / 64'd10;
                d    = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Single shift-and-add-3 correction: adds 3 to a BCD digit that is 5 or more.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/bcd_seq_conv.sv
// Multi-cycle binary-to-BCD converter, one shift-and-add-3 step per clock, with
// optional sign-magnitude input, sticky overflow and a start/ready/done handshake.
module bcd_seq_conv
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W     = 12,
    parameter int unsigned DIGITS    = 4,
    parameter bit          SIGNED_EN = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [BIN_W-1:0]              binary,
    output logic                          ready,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          sign,
    output logic                          overflow
);

    localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = clog2(BIN_W + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   dig_q, dig_d, dig_adj;
    logic [BIN_W-1:0]   mag_q, mag_d;
    logic               acc_q, acc_d;
    logic               neg_q, neg_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               sign_q, sign_d;
    logic               ovf_q, ovf_d;

    logic               op_neg;
    logic [BIN_W-1:0]   op_mag;
    logic [BCD_W+BIN_W:0] stepped;
    logic               last_step;

    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (dig_q[BCD_DIGIT_W*k +: BCD_DIGIT_W]),
            .dout (dig_adj[BCD_DIGIT_W*k +: BCD_DIGIT_W])
        );
    end

    // Negating the most-negative value wraps to 2^(BIN_W-1), which is the correct magnitude.
    assign op_neg    = SIGNED_EN && binary[BIN_W-1];
    assign op_mag    = op_neg ? (~binary + 1'b1) : binary;
    // Top bit of stepped is whatever falls out of the most significant digit.
    assign stepped   = {dig_adj, mag_q, 1'b0};
    assign last_step = (cnt_q == CNT_W'(BIN_W - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        mag_d   = mag_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        bcd_d   = bcd_q;
        sign_d  = sign_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = (state_q == DONE) ? IDLE : state_q;
                if (start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    dig_d   = '0;
                    mag_d   = op_mag;
                    acc_d   = 1'b0;
                    neg_d   = op_neg;
                end
            end
            SHIFT: begin
                dig_d = stepped[BCD_W+BIN_W-1:BIN_W];
                mag_d = stepped[BIN_W-1:0];
                acc_d = acc_q | stepped[BCD_W+BIN_W];
                cnt_d = cnt_q + 1'b1;
                if (last_step) begin
                    state_d = DONE;
                    bcd_d   = stepped[BCD_W+BIN_W-1:BIN_W];
                    sign_d  = neg_q;
                    ovf_d   = acc_q | stepped[BCD_W+BIN_W];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dig_q   <= '0;
            mag_q   <= '0;
            acc_q   <= 1'b0;
            neg_q   <= 1'b0;
            bcd_q   <= '0;
            sign_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            mag_q   <= mag_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            bcd_q   <= bcd_d;
            sign_q  <= sign_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ready    = (state_q == IDLE) || (state_q == DONE);
    assign busy     = (state_q == SHIFT);
    assign done     = (state_q == DONE);
    assign bcd      = bcd_q;
    assign sign     = sign_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Bench for bcd_seq_conv: three parameterisations driven in lockstep, checked against
// a decimal-arithmetic reference model.
module tb_bcd_seq_conv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] binary;

    logic        ready0, busy0, done0, sign0, ovf0;
    logic [15:0] bcd0;
    logic        ready1, busy1, done1, sign1, ovf1;
    logic [15:0] bcd1;
    logic        ready2, busy2, done2, sign2, ovf2;
    logic [11:0] bcd2;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] prev0;

    always #5 clk = ~clk;

    bcd_seq_conv u_dut_u4 (
        .clk(clk), .rst_n(rst_n), .start(start), .binary(binary),
        .ready(ready0), .busy(busy0), .done(done0), .bcd(bcd0), .sign(sign0), .overflow(ovf0)
    );

    bcd_seq_conv #(.SIGNED_EN(1'b1)) u_dut_s4 (
        .clk(clk), .rst_n(rst_n), .start(start), .binary(binary),
        .ready(ready1), .busy(busy1), .done(done1), .bcd(bcd1), .sign(sign1), .overflow(ovf1)
    );

    bcd_seq_conv #(.DIGITS(3)) u_dut_u3 (
        .clk(clk), .rst_n(rst_n), .start(start), .binary(binary),
        .ready(ready2), .busy(busy2), .done(done2), .bcd(bcd2), .sign(sign2), .overflow(ovf2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Expected BCD of a 12-bit input from plain decimal arithmetic.
    function automatic logic [31:0] model(input int v, input int digits, input bit sgn,
                                          output logic s, output logic ov);
        int          mag;
        int          lim;
        logic [31:0] r;
        s   = 1'b0;
        mag = v;
        if (sgn && v >= 2048) begin
            s   = 1'b1;
            mag = 4096 - v;
        end
        lim = 1;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        ov  = (mag >= lim);
        mag = mag % lim;
        r   = '0;
        for (int k = 0; k < digits; k++) begin
            r[4*k +: 4] = 4'(mag % 10);
            mag         = mag / 10;
        end
        return r;
    endfunction

    task automatic check_results(input int v);
        logic        s;
        logic        ov;
        logic [31:0] e;
        e = model(v, 4, 1'b0, s, ov);
        check($sformatf("bcd_u4(%0d)", v), {16'h0, bcd0}, e);
        check("sign_u4", 32'(sign0), 32'(s));
        check("ovf_u4", 32'(ovf0), 32'(ov));
        prev0 = e[15:0];
        e = model(v, 4, 1'b1, s, ov);
        check($sformatf("bcd_s4(%0d)", v), {16'h0, bcd1}, e);
        check("sign_s4", 32'(sign1), 32'(s));
        check("ovf_s4", 32'(ovf1), 32'(ov));
        e = model(v, 3, 1'b0, s, ov);
        check($sformatf("bcd_u3(%0d)", v), {20'h0, bcd2}, e);
        check("sign_u3", 32'(sign2), 32'(s));
        check("ovf_u3", 32'(ovf2), 32'(ov));
    endtask

    // Counts edges until done is seen, bounded so a stuck DUT cannot hang the run.
    task automatic wait_done(output int n, input bit hold_chk);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (hold_chk && n == 6) check("hold_mid", 32'(bcd0), 32'(prev0));
        end while (!done0 && n < 40);
    endtask

    task automatic run_conv(input int v);
        int n;
        @(negedge clk);
        check("ready_pre", 32'(ready0), 32'd1);
        start  = 1'b1;
        binary = 12'(v);
        @(posedge clk);
        #1;
        start  = 1'b0;
        binary = 12'($urandom_range(0, 4095));
        check("busy", 32'(busy0), 32'd1);
        wait_done(n, 1'b1);
        check("latency", n, 12);
        check("done_sync", 32'({done1, done2}), 32'd3);
        check("ready_done", 32'(ready0), 32'd1);
        check("busy_done", 32'(busy0), 32'd0);
        check_results(v);
        @(posedge clk);
        #1;
        check("done_pulse", 32'(done0), 32'd0);
        check("hold_after", 32'(bcd0), 32'(prev0));
    endtask

    initial begin
        int n;
        int seen;
        rst_n  = 1'b0;
        start  = 1'b0;
        binary = '0;
        prev0  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready0), 32'd1);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_bcd", 32'(bcd0), 32'd0);
        check("rst_flags", 32'({sign0, ovf0, sign1, ovf1}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_conv(4095);
        run_conv(0);
        run_conv(1);
        repeat (4) @(posedge clk);
        #1;
        check("hold_idle", 32'(bcd0), 32'(prev0));
        run_conv(12'h800);
        run_conv(12'hFFF);
        run_conv(1000);
        run_conv(999);

        // start held high: mid-SHIFT start ignored, next start taken in the DONE cycle
        @(negedge clk);
        start  = 1'b1;
        binary = 12'd123;
        @(posedge clk);
        #1;
        binary = 12'd456;
        wait_done(n, 1'b1);
        check("stream_lat", n, 12);
        check_results(123);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("stream_busy", 32'(busy0), 32'd1);
        wait_done(n, 1'b0);
        check("stream_gap", n + 1, 13);
        check_results(456);
        @(posedge clk);
        #1;

        // reset asserted after step 5 of a conversion
        @(negedge clk);
        start  = 1'b1;
        binary = 12'd555;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_bcd", 32'(bcd0), 32'd0);
        check("abort_flags", 32'({sign0, ovf0, done0, busy0}), 32'd0);
        check("abort_ready", 32'(ready0), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        prev0 = '0;
        seen  = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done0) seen++;
        end
        check("abort_no_done", seen, 0);
        run_conv(789);

        for (int i = 0; i < 20; i++) begin
            run_conv(int'($urandom_range(0, 4095)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
